fifo_write_arbiter: RTL

Single-clock round-robin arbiter that shares the FIFO write port among `NUM_REQ` producers in the write domain. It selects one requester per cycle, forwards that requester's word to the FIFO memory's `write_inc`/`write_data` inputs, and honours `write_full` so no beat is lost or duplicated. An optional burst lock keeps a grant on one requester for up to `BURST_LEN` consecutive beats.

---
 rtl/fifo_arb_pkg.sv | 11 +
 rtl/rr_priority_picker.sv | 32 +++
 rtl/fifo_write_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and width helper for the FIFO write-port arbiter.
// Contents: arb_state_t (ARB_IDLE/ARB_LOCK), ARB_IDX_W(n) index width (min 1).
package fifo_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;

   function automatic int ARB_IDX_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin picker, first valid at or after rr_ptr.
// Ports: valid (per-requester), rr_ptr (highest-priority index) ->
//        pick_oh (one-hot pick), pick_idx (its index), any_valid (some valid set).
module rr_priority_picker
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
)(
   input  logic [NUM_REQ-1:0]             valid,
   input  logic [ARB_IDX_W(NUM_REQ)-1:0]  rr_ptr,
   output logic [NUM_REQ-1:0]             pick_oh,
   output logic [ARB_IDX_W(NUM_REQ)-1:0]  pick_idx,
   output logic                           any_valid
);

   localparam int IW = ARB_IDX_W(NUM_REQ);

   // Scan offsets from farthest to nearest so the nearest valid wins last.
   always_comb begin
      pick_oh  = '0;
      pick_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
            pick_oh  = NUM_REQ'(1) << ((int'(rr_ptr) + i) % NUM_REQ);
            pick_idx = IW'((int'(rr_ptr) + i) % NUM_REQ);
         end
      end
   end

   assign any_valid = |valid;

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter sharing the FIFO write port among NUM_REQ producers.
// Ports: write_clk/write_rst (sync, active-high); req_valid/req_data/req_ready per requester;
//        write_full in; write_inc/write_data to FIFO memory; grant_id last granted; locked.
// Optional burst lock enabled by defining FIFO_WRITE_ARB_BURST_EN (holds a grant up to BURST_LEN beats).
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATASIZE  = 8,
   parameter int BURST_LEN = 4
)(
   input  logic                           write_clk,
   input  logic                           write_rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*DATASIZE-1:0]    req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic                           write_full,
   output logic                           write_inc,
   output logic [DATASIZE-1:0]            write_data,
   output logic [ARB_IDX_W(NUM_REQ)-1:0]  grant_id,
   output logic                           locked
);

   localparam int IW = ARB_IDX_W(NUM_REQ);

   logic [IW-1:0]      rr_ptr, pick_idx, gnt_idx;
   logic [NUM_REQ-1:0] pick_oh, grant;
   logic               any_valid, xfer, lock_st;

   rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .valid     (req_valid),
      .rr_ptr    (rr_ptr),
      .pick_oh   (pick_oh),
      .pick_idx  (pick_idx),
      .any_valid (any_valid)
   );

`ifdef FIFO_WRITE_ARB_BURST_EN
   localparam int CW = $clog2(BURST_LEN + 1);

   arb_state_t    state, state_nxt;
   logic [IW-1:0] owner;
   logic [CW-1:0] beat_cnt;
   logic          last_beat;

   assign last_beat = CW'(beat_cnt + 1'b1) == CW'(BURST_LEN);
   assign lock_st   = state == ARB_LOCK;

   always_ff @(posedge write_clk)
      state <= write_rst ? ARB_IDLE : state_nxt;

   // A dropped owner valid releases the lock even while the FIFO is full.
   always_comb begin
      state_nxt = state;
      if (state == ARB_IDLE)
         state_nxt = (xfer && BURST_LEN > 1) ? ARB_LOCK : ARB_IDLE;
      else if (!req_valid[owner] || (xfer && last_beat))
         state_nxt = ARB_IDLE;
   end

   always_comb begin
      grant   = '0;
      gnt_idx = pick_idx;
      if (!write_rst && !write_full) begin
         if (lock_st) begin
            gnt_idx      = owner;
            grant[owner] = req_valid[owner];
         end else
            grant = any_valid ? pick_oh : '0;
      end
   end

   always_ff @(posedge write_clk)
      if (write_rst) begin
         owner    <= '0;
         beat_cnt <= '0;
      end else if (xfer) begin
         owner    <= lock_st ? owner : pick_idx;
         beat_cnt <= lock_st ? beat_cnt + 1'b1 : CW'(1);
      end
`else
   logic unused_burst_len;

   assign unused_burst_len = BURST_LEN[0];
   assign lock_st          = 1'b0;

   always_comb begin
      grant   = (!write_rst && !write_full && any_valid) ? pick_oh : '0;
      gnt_idx = pick_idx;
   end
`endif

   assign xfer      = |(req_valid & grant);
   assign req_ready = grant;
   assign write_inc = xfer;
   assign locked    = lock_st;

   always_comb begin
      write_data = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant[i] && req_valid[i]) write_data = req_data[i*DATASIZE +: DATASIZE];
   end

   // rr_ptr only advances on unlocked grants; a locked burst keeps the pointer set at lock entry.
   always_ff @(posedge write_clk)
      if (write_rst) begin
         rr_ptr   <= '0;
         grant_id <= '0;
      end else if (xfer) begin
         grant_id <= gnt_idx;
         if (!lock_st) rr_ptr <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end

endmodule
